i2c_reg_ctrl: RTL and testbench

- Register-access sequencer directly upstream of i2c_master.
- Accepts one register read or write request per handshake from a system-side client.
- Converts the request into a single i2c_master command: pointer write, or pointer write followed by repeated-START read. Streams write bytes on the master's wr_ready strobes and packs rd_valid bytes into a response word.
- Retries on NACK with a backoff gap, and reports timeout if the master never signals done.

---
 rtl/i2c_reg_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: register-access sequencer sitting in front of i2c_master.
// Turns one register read/write request into a single master command
// (pointer write, or pointer write + repeated-START read). It streams write
// bytes on m_wr_ready, packs m_rd_valid bytes into rsp_rdata, retries NACKed
// attempts after a backoff gap, and aborts with a timeout status if the
// master never reports done.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   req_*                      client request handshake and fields
//   rsp_*                      one-cycle response strobe plus held result fields
//   m_*                        command/data interface to i2c_master
//   stat_txn, stat_nack        saturating counters (only with I2C_REG_CTRL_STATS_EN)
//
// Optional feature macro: I2C_REG_CTRL_STATS_EN
module i2c_reg_ctrl #(
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned RETRY_GAP   = 1000,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [6:0]  req_dev,
  input  logic [7:0]  req_reg,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_attempts,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_wr_len,
  output logic [7:0]  m_rd_len,
  output logic [7:0]  m_wr_data,
  input  logic        m_wr_ready,
  input  logic [7:0]  m_rd_data,
  input  logic        m_rd_valid,
  input  logic        m_done,
  input  logic        m_ack_error
`ifdef I2C_REG_CTRL_STATS_EN
  ,
  output logic [15:0] stat_txn,
  output logic [15:0] stat_nack
`endif
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned GapW = $clog2(RETRY_GAP + 1) + 1;

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StBackoff, StResp} state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [7:0]      reg_q, reg_d;
  logic [2:0]      len_q, len_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      attempts_q, attempts_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      rd_cnt_q, rd_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [2:0]      rsp_attempts_q, rsp_attempts_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_wr_len_q, m_wr_len_d;
  logic [7:0]      m_rd_len_q, m_rd_len_d;
  logic [7:0]      m_wr_data_q, m_wr_data_d;

  logic [2:0] len_clamp;
  logic [2:0] wr_last;
  logic [2:0] nxt_idx;
  logic [4:0] sh;
  logic       go_resp;
  logic [1:0] status_n;

  assign len_clamp = (req_len > 3'd4) ? 3'd4 : req_len;
  // Index of the last byte in the write phase; reads only send the pointer.
  assign wr_last   = write_q ? len_q : 3'd0;
  assign nxt_idx   = idx_q + 3'd1;
  // Byte k of the payload is wdata[8*(L-k)+7 -: 8].
  assign sh        = 5'({len_q - nxt_idx, 3'b000});

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    reg_d          = reg_q;
    len_d          = len_q;
    wdata_d        = wdata_q;
    attempts_d     = attempts_q;
    idx_d          = idx_q;
    rd_cnt_d       = rd_cnt_q;
    rdata_d        = rdata_q;
    tmo_d          = tmo_q;
    gap_d          = gap_q;
    rsp_status_d   = rsp_status_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_attempts_d = rsp_attempts_q;
    m_addr_d       = m_addr_q;
    m_wr_len_d     = m_wr_len_q;
    m_rd_len_d     = m_rd_len_q;
    m_wr_data_d    = m_wr_data_q;
    go_resp        = 1'b0;
    status_n       = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d    = req_write;
          reg_d      = req_reg;
          len_d      = len_clamp;
          wdata_d    = req_wdata;
          attempts_d = 3'd0;
          m_addr_d   = req_dev;
          m_wr_len_d = req_write ? ({5'd0, len_clamp} + 8'd1) : 8'd1;
          m_rd_len_d = req_write ? 8'd0 : {5'd0, len_clamp};
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        attempts_d  = attempts_q + 3'd1;
        idx_d       = 3'd0;
        rd_cnt_d    = 3'd0;
        rdata_d     = '0;
        tmo_d       = '0;
        m_wr_data_d = reg_q;
        state_d     = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        // Next byte is loaded after the strobe; extra strobes hold the last byte.
        if (m_wr_ready && (idx_q < wr_last)) begin
          idx_d       = nxt_idx;
          m_wr_data_d = 8'(wdata_q >> sh);
        end
        if (m_rd_valid && !write_q && (rd_cnt_q < len_q)) begin
          rdata_d  = {rdata_q[23:0], m_rd_data};
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
        // m_done takes priority over a coincident timeout.
        if (m_done) begin
          if (!m_ack_error) begin
            go_resp = 1'b1;
            status_n = 2'b00;
          end else if (32'(attempts_q) <= MAX_RETRY) begin
            gap_d   = '0;
            state_d = StBackoff;
          end else begin
            go_resp = 1'b1;
            status_n = 2'b01;
          end
        end else if (tmo_d == TmoW'(TIMEOUT_CYC - 1)) begin
          go_resp = 1'b1;
          status_n = 2'b10;
        end
      end
      StBackoff: begin
        gap_d = gap_q + 1'b1;
        if ((RETRY_GAP <= 1) || (gap_q == GapW'(RETRY_GAP - 1))) begin
          state_d = StLaunch;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (go_resp) begin
      state_d        = StResp;
      rsp_status_d   = status_n;
      rsp_attempts_d = attempts_q;
      rsp_rdata_d    = ((status_n == 2'b00) && !write_q) ? rdata_d : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      write_q        <= 1'b0;
      reg_q          <= '0;
      len_q          <= '0;
      wdata_q        <= '0;
      attempts_q     <= '0;
      idx_q          <= '0;
      rd_cnt_q       <= '0;
      rdata_q        <= '0;
      tmo_q          <= '0;
      gap_q          <= '0;
      rsp_status_q   <= '0;
      rsp_rdata_q    <= '0;
      rsp_attempts_q <= '0;
      m_addr_q       <= '0;
      m_wr_len_q     <= '0;
      m_rd_len_q     <= '0;
      m_wr_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      reg_q          <= reg_d;
      len_q          <= len_d;
      wdata_q        <= wdata_d;
      attempts_q     <= attempts_d;
      idx_q          <= idx_d;
      rd_cnt_q       <= rd_cnt_d;
      rdata_q        <= rdata_d;
      tmo_q          <= tmo_d;
      gap_q          <= gap_d;
      rsp_status_q   <= rsp_status_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_attempts_q <= rsp_attempts_d;
      m_addr_q       <= m_addr_d;
      m_wr_len_q     <= m_wr_len_d;
      m_rd_len_q     <= m_rd_len_d;
      m_wr_data_q    <= m_wr_data_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign m_start      = (state_q == StLaunch);
  assign m_rw         = 1'b0;
  assign rsp_status   = rsp_status_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_attempts = rsp_attempts_q;
  assign m_addr       = m_addr_q;
  assign m_wr_len     = m_wr_len_q;
  assign m_rd_len     = m_rd_len_q;
  assign m_wr_data    = m_wr_data_q;

`ifdef I2C_REG_CTRL_STATS_EN
  logic [15:0] stat_txn_q, stat_txn_d;
  logic [15:0] stat_nack_q, stat_nack_d;

  always_comb begin
    stat_txn_d  = stat_txn_q;
    stat_nack_d = stat_nack_q;
    if ((state_q == StResp) && (stat_txn_q != 16'hFFFF)) begin
      stat_txn_d = stat_txn_q + 16'd1;
    end
    if ((state_q == StWait) && m_done && m_ack_error && (stat_nack_q != 16'hFFFF)) begin
      stat_nack_d = stat_nack_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn_q  <= '0;
      stat_nack_q <= '0;
    end else begin
      stat_txn_q  <= stat_txn_d;
      stat_nack_q <= stat_nack_d;
    end
  end

  assign stat_txn  = stat_txn_q;
  assign stat_nack = stat_nack_q;
`endif

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed self-checking bench for i2c_reg_ctrl with a hand-driven master stub.
module tb_i2c_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_attempts;
  logic        m_start, m_rw;
  logic [6:0]  m_addr;
  logic [7:0]  m_wr_len, m_rd_len, m_wr_data, m_rd_data;
  logic        m_wr_ready, m_rd_valid, m_done, m_ack_error;
`ifdef I2C_REG_CTRL_STATS_EN
  logic [15:0] stat_txn, stat_nack;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_reg_ctrl #(
    .MAX_RETRY   (2),
    .RETRY_GAP   (10),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_dev      (req_dev),
    .req_reg      (req_reg),
    .req_len      (req_len),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_rdata    (rsp_rdata),
    .rsp_attempts (rsp_attempts),
    .m_start      (m_start),
    .m_addr       (m_addr),
    .m_rw         (m_rw),
    .m_wr_len     (m_wr_len),
    .m_rd_len     (m_rd_len),
    .m_wr_data    (m_wr_data),
    .m_wr_ready   (m_wr_ready),
    .m_rd_data    (m_rd_data),
    .m_rd_valid   (m_rd_valid),
    .m_done       (m_done),
    .m_ack_error  (m_ack_error)
`ifdef I2C_REG_CTRL_STATS_EN
    ,
    .stat_txn     (stat_txn),
    .stat_nack    (stat_nack)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a request in an idle cycle; returns in the LAUNCH cycle.
  task automatic send(input logic w, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [2:0] len, input logic [31:0] wd);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_dev   = dev;
    req_reg   = rg;
    req_len   = len;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    chk("m_start_launch", 32'(m_start), 32'd1);
    chk("m_rw", 32'(m_rw), 32'd0);
  endtask

  task automatic wr_strobe(input string tag, input logic [7:0] exp);
    tick();
    m_wr_ready = 1'b1;
    chk(tag, 32'(m_wr_data), 32'(exp));
    tick();
    m_wr_ready = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] b);
    m_rd_data  = b;
    m_rd_valid = 1'b1;
    tick();
    m_rd_valid = 1'b0;
  endtask

  task automatic done(input logic err);
    m_done      = 1'b1;
    m_ack_error = err;
    tick();
    m_done      = 1'b0;
    m_ack_error = 1'b0;
  endtask

  task automatic resp(input logic [1:0] st, input logic [2:0] att, input logic [31:0] rd);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_status", 32'(rsp_status), 32'(st));
    chk("rsp_attempts", 32'(rsp_attempts), 32'(att));
    chk("rsp_rdata", rsp_rdata, rd);
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    tick();
    chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  // Counts idle cycles from the cycle after a NACK until the retry's m_start.
  task automatic gap_check(input string tag);
    int cnt = 0;
    while (!m_start && cnt < 100) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    logic seen;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_dev = '0; req_reg = '0; req_len = '0;
    req_wdata = '0; m_wr_ready = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0;
    m_done = 1'b0; m_ack_error = 1'b0;
    #3;
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_m_wr_len", 32'(m_wr_len), 32'd0);
    chk("rst_rsp_attempts", 32'(rsp_attempts), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Write len=2: pointer then 0xBE, 0xEF; a fourth strobe holds the last byte.
    send(1'b1, 7'h50, 8'h10, 3'd2, 32'h0000BEEF);
    chk("w_m_addr", 32'(m_addr), 32'h50);
    chk("w_wr_len", 32'(m_wr_len), 32'd3);
    chk("w_rd_len", 32'(m_rd_len), 32'd0);
    tick();
    chk("m_start_one_cycle", 32'(m_start), 32'd0);
    wr_strobe("w_byte0", 8'h10);
    wr_strobe("w_byte1", 8'hBE);
    wr_strobe("w_byte2", 8'hEF);
    wr_strobe("w_byte_extra", 8'hEF);
    done(1'b0);
    resp(2'b00, 3'd1, 32'd0);

    // Read len=3; a fourth read strobe must be ignored.
    send(1'b0, 7'h50, 8'h20, 3'd3, 32'd0);
    chk("r_wr_len", 32'(m_wr_len), 32'd1);
    chk("r_rd_len", 32'(m_rd_len), 32'd3);
    wr_strobe("r_ptr", 8'h20);
    rd_byte(8'h11);
    rd_byte(8'h22);
    rd_byte(8'h33);
    rd_byte(8'h44);
    done(1'b0);
    resp(2'b00, 3'd1, 32'h00112233);

    // Length 7 clamps to 4.
    send(1'b1, 7'h2A, 8'h05, 3'd7, 32'h01020304);
    chk("c_wr_len", 32'(m_wr_len), 32'd5);
    chk("c_rd_len", 32'(m_rd_len), 32'd0);
    wr_strobe("c_byte0", 8'h05);
    wr_strobe("c_byte1", 8'h01);
    wr_strobe("c_byte2", 8'h02);
    wr_strobe("c_byte3", 8'h03);
    wr_strobe("c_byte4", 8'h04);
    done(1'b0);
    resp(2'b00, 3'd1, 32'd0);

    // No slave: three NACKed attempts separated by 10 idle cycles.
    send(1'b0, 7'h50, 8'h30, 3'd1, 32'd0);
    wr_strobe("n_ptr1", 8'h30);
    done(1'b1);
    m_done = 1'b1;  // stray done during backoff must be ignored
    tick();
    m_done = 1'b0;
    cnt = 1;
    while (!m_start && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("n_gap1", 32'(cnt), 32'd10);
    wr_strobe("n_ptr2", 8'h30);
    done(1'b1);
    gap_check("n_gap2");
    wr_strobe("n_ptr3", 8'h30);
    rd_byte(8'h77);
    done(1'b1);
    resp(2'b01, 3'd3, 32'd0);
`ifdef I2C_REG_CTRL_STATS_EN
    chk("stat_txn_4", 32'(stat_txn), 32'd4);
    chk("stat_nack_3", 32'(stat_nack), 32'd3);
`endif

    // NACK then ACK; partial data from the first attempt is discarded.
    send(1'b0, 7'h50, 8'h40, 3'd1, 32'd0);
    wr_strobe("a_ptr1", 8'h40);
    rd_byte(8'h99);
    done(1'b1);
    gap_check("a_gap");
    wr_strobe("a_ptr2", 8'h40);
    rd_byte(8'h5A);
    done(1'b0);
    resp(2'b00, 3'd2, 32'h0000005A);

    // Timeout: no m_done, rsp_valid exactly 100 cycles after m_start.
    send(1'b1, 7'h11, 8'h00, 3'd0, 32'd0);
    chk("t_wr_len", 32'(m_wr_len), 32'd1);
    cnt = 0;
    while (!rsp_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("t_cycles", 32'(cnt), 32'd100);
    resp(2'b10, 3'd1, 32'd0);

    // Asynchronous reset during WAIT.
    send(1'b0, 7'h50, 8'h22, 3'd2, 32'd0);
    wr_strobe("x_ptr", 8'h22);
    rd_byte(8'hAB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("x_m_start", 32'(m_start), 32'd0);
    chk("x_m_addr", 32'(m_addr), 32'd0);
    chk("x_m_wr_len", 32'(m_wr_len), 32'd0);
    chk("x_m_rd_len", 32'(m_rd_len), 32'd0);
    chk("x_m_wr_data", 32'(m_wr_data), 32'd0);
    chk("x_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("x_rsp_status", 32'(rsp_status), 32'd0);
    chk("x_rsp_attempts", 32'(rsp_attempts), 32'd0);
    chk("x_rsp_rdata", rsp_rdata, 32'd0);
`ifdef I2C_REG_CTRL_STATS_EN
    chk("x_stat_txn", 32'(stat_txn), 32'd0);
    chk("x_stat_nack", 32'(stat_nack), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("x_no_rsp", 32'(seen), 32'd0);
    send(1'b1, 7'h3C, 8'h01, 3'd0, 32'd0);
    chk("x_wr_len", 32'(m_wr_len), 32'd1);
    chk("x_rd_len", 32'(m_rd_len), 32'd0);
    chk("x_m_addr2", 32'(m_addr), 32'h3C);
    wr_strobe("x_byte0", 8'h01);
    done(1'b0);
    resp(2'b00, 3'd1, 32'd0);
`ifdef I2C_REG_CTRL_STATS_EN
    chk("x_stat_txn_1", 32'(stat_txn), 32'd1);
    chk("x_stat_nack_0", 32'(stat_nack), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
